// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALT} fetch_state_e;
  typedef enum logic [1:0] {KIND_BEQ, KIND_J, KIND_JAL, KIND_JR} redir_kind_e;
  localparam logic [31:0] DEF_HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] PC_STEP = 32'd4;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: combinational redirect target and JR alignment check
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  input  logic [25:0] jaddr,
  input  logic [31:0] rs,
  output logic [31:0] target,
  output logic        misaligned
);
  logic [31:0] pc4;
  assign pc4 = pc + PC_STEP;
  assign target = kind == KIND_JR  ? {rs[31:2], 2'b00} :
                  kind == KIND_BEQ ? pc4 + {{14{imm[15]}}, imm, 2'b00} :
                                     {pc4[31:28], jaddr, 2'b00};
  assign misaligned = kind == KIND_JR && |rs[1:0];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC, IF/ID register with valid/ready, redirects and halt parking
// FETCH_PERF_CNT_EN builds the fetched/stall counters; otherwise they read 0.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = DEF_HALT_WORD
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_adr,
  input  logic [31:0] imem_data,
  input  logic        redir_valid,
  input  logic [1:0]  redir_kind,
  input  logic [31:0] redir_pc,
  input  logic [15:0] redir_imm,
  input  logic [25:0] redir_jaddr,
  input  logic [31:0] redir_rs,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic        halted,
  output logic        adr_err,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_stalls
);
  fetch_state_e state;
  logic [31:0] pc, target;
  logic misaligned, redir, adv;
  next_pc_calc u_next_pc (
    .kind(redir_kind),
    .pc(redir_pc),
    .imm(redir_imm),
    .jaddr(redir_jaddr),
    .rs(redir_rs),
    .target(target),
    .misaligned(misaligned)
  );
  assign imem_adr = pc;
  assign redir = redir_valid && state != BOOT;
  assign adv = !id_valid || id_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      halted      <= 1'b0;
      adr_err     <= 1'b0;
    end else begin
      adr_err <= redir && misaligned;
      if (redir) begin
        pc       <= target;
        id_valid <= 1'b0;
        state    <= RUN;
        halted   <= 1'b0;
      end else if (state == BOOT) begin
        state <= RUN;
      end else if (state == RUN && adv) begin
        if (imem_data == HALT_WORD) begin
          state    <= HALT;
          halted   <= 1'b1;
          id_valid <= 1'b0;
        end else begin
          id_instr    <= imem_data;
          id_pc       <= pc;
          id_pc_plus4 <= pc + PC_STEP;
          id_valid    <= 1'b1;
          pc          <= pc + PC_STEP;
        end
      end else if (state == HALT && id_ready) begin
        id_valid <= 1'b0;
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  logic load, stall;
  assign load  = !redir && state == RUN && adv && imem_data != HALT_WORD;
  assign stall = state == RUN && id_valid && !id_ready;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stalls  <= '0;
    end else begin
      if (load) perf_fetched <= perf_fetched + 32'd1;
      if (stall) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`else
  assign perf_fetched = '0;
  assign perf_stalls  = '0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench with an address-stream reference model
module tb_instr_fetch;
  localparam logic [31:0] HW = 32'hFFFF_FFFF;
  localparam logic [31:0] WA = 32'h1111_0001, WB = 32'h2222_0002, WC = 32'h3333_0003;
  localparam logic [31:0] WD = 32'h4444_0004, WE = 32'h5555_0005, WF = 32'h6666_0006;
  typedef struct packed {logic [31:0] instr, pc, pc4;} item_t;

  logic clk = 0, rst_n = 1;
  logic [31:0] imem_adr, imem_data, redir_pc, redir_rs, id_instr, id_pc, id_pc_plus4;
  logic [31:0] perf_fetched, perf_stalls;
  logic [1:0] redir_kind = 0;
  logic [15:0] redir_imm = 0;
  logic [25:0] redir_jaddr = 0;
  logic redir_valid = 0, id_ready = 1, id_valid, halted, adr_err;
  logic [31:0] mem [256];
  item_t exp_q[$];
  logic [31:0] mpc = 0;
  logic m_halt = 0, exp_err = 0;
  int tests = 0, fails = 0, hs = 0;

  assign imem_data = mem[imem_adr[9:2]];
  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_adr(imem_adr), .imem_data(imem_data),
    .redir_valid(redir_valid), .redir_kind(redir_kind), .redir_pc(redir_pc),
    .redir_imm(redir_imm), .redir_jaddr(redir_jaddr), .redir_rs(redir_rs),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .id_pc_plus4(id_pc_plus4), .halted(halted), .adr_err(adr_err),
    .perf_fetched(perf_fetched), .perf_stalls(perf_stalls)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  // Expected delivery stream: sequential words from mpc until a halt word.
  task automatic topup();
    while (exp_q.size() < 4 && !m_halt) begin
      if (mem[mpc[9:2]] == HW) m_halt = 1;
      else begin
        exp_q.push_back('{mem[mpc[9:2]], mpc, mpc + 32'd4});
        mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    topup();
  endtask

  task automatic redirect(input logic [1:0] k, input logic [31:0] p, input logic [15:0] imm,
                          input logic [25:0] ja, input logic [31:0] rs);
    logic signed [31:0] off;
    logic [31:0] t;
    off = $signed(imm);
    case (k)
      2'd0: t = p + 32'd4 + 32'(off * 4);
      2'd3: t = rs & ~32'd3;
      default: t = ((p + 32'd4) & 32'hF000_0000) | (32'(ja) * 32'd4);
    endcase
    redir_valid = 1; redir_kind = k; redir_pc = p; redir_imm = imm; redir_jaddr = ja; redir_rs = rs;
    exp_err = (k == 2'd3) && (rs[1:0] != 0);
    exp_q.delete();
    mpc = t;
    m_halt = 0;
    topup();
  endtask

  always @(negedge clk) begin
    if (rst_n && id_valid && id_ready && !redir_valid) begin
      if (exp_q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_handshake: got pc %h expected none", id_pc);
      end else begin
        item_t e;
        e = exp_q.pop_front();
        hs++;
        chk("sb_instr", id_instr, e.instr);
        chk("sb_pc", id_pc, e.pc);
        chk("sb_pc4", id_pc_plus4, e.pc4);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    redir_pc = 0; redir_rs = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom & 32'h7FFF_FFFF;
    mem[0] = WA; mem[1] = WB; mem[2] = WC; mem[3] = WD;
    #2 rst_n = 0;
    #3;
    chk("rst_adr", imem_adr, 0);
    chk("rst_valid", 32'(id_valid), 0);
    chk("rst_instr", id_instr, 0);
    chk("rst_pc", id_pc, 0);
    chk("rst_pc4", id_pc_plus4, 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_adr_err", 32'(adr_err), 0);
    chk("rst_perf_f", perf_fetched, 0);
    chk("rst_perf_s", perf_stalls, 0);
    topup();
    @(posedge clk); #1 rst_n = 1;
    step();
    chk("boot_no_fetch", 32'(id_valid), 0);
    step();
    chk("first_valid", 32'(id_valid), 1);
    chk("first_instr", id_instr, WA);
    step();
    chk("second_instr", id_instr, WB);
    id_ready = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_instr", id_instr, WB);
      chk("stall_adr", imem_adr, 32'h8);
      chk("stall_valid", 32'(id_valid), 1);
    end
`ifdef FETCH_PERF_CNT_EN
    chk("perf_stalls", perf_stalls, 3);
`else
    chk("perf_stalls_tied", perf_stalls, 0);
`endif
    id_ready = 1;
    step();
    chk("after_stall", id_instr, WC);
    redirect(2'd0, 32'h10, 16'hFFFE, 0, 0);
    step();
    chk("beq_adr", imem_adr, 32'h0C);
    chk("beq_bubble", 32'(id_valid), 0);
    redir_valid = 0; exp_err = 0;
    step();
    chk("beq_instr", id_instr, WD);
    chk("beq_pc", id_pc, 32'h0C);
    mem[8'h40] = WE;
    redirect(2'd1, 32'hF000_0000, 16'h0, 26'h000_0040, 0);
    step();
    chk("j_adr", imem_adr, 32'hF000_0100);
    chk("j_adr_err", 32'(adr_err), 0);
    redir_valid = 0; exp_err = 0;
    step();
    chk("j_instr", id_instr, WE);
    mem[8'h80] = WF;
    redirect(2'd3, 0, 0, 0, 32'h0000_0203);
    step();
    chk("jr_adr", imem_adr, 32'h200);
    chk("jr_adr_err", 32'(adr_err), 1);
    redir_valid = 0; exp_err = 0;
    step();
    chk("jr_err_pulse", 32'(adr_err), 0);
    chk("jr_instr", id_instr, WF);
    mem[2] = HW;
    redirect(2'd3, 0, 0, 0, 0);
    step();
    redir_valid = 0; exp_err = 0;
    for (int i = 0; i < 10 && !halted; i++) step();
    chk("halted", 32'(halted), 1);
    chk("halt_valid", 32'(id_valid), 0);
    chk("halt_adr", imem_adr, 32'h8);
    step(); step(); step();
    chk("halt_hold", 32'(halted), 1);
    chk("halt_adr_hold", imem_adr, 32'h8);
    mem[2] = WC;
    redirect(2'd3, 0, 0, 0, 0);
    step();
    chk("unhalt", 32'(halted), 0);
    redir_valid = 0; exp_err = 0;
    step();
    chk("refetch_a", id_instr, WA);
    id_ready = 0;
    step(); step();
    redirect(2'd0, 32'h40, 16'h0010, 0, 0);
    #1 rst_n = 0;
    #1;
    chk("mid_rst_adr", imem_adr, 0);
    chk("mid_rst_valid", 32'(id_valid), 0);
    chk("mid_rst_instr", id_instr, 0);
    chk("mid_rst_pc", id_pc, 0);
    chk("mid_rst_pc4", id_pc_plus4, 0);
    chk("mid_rst_halted", 32'(halted), 0);
    chk("mid_rst_perf", perf_stalls, 0);
    redir_valid = 0; exp_err = 0; id_ready = 1;
    exp_q.delete(); mpc = 0; m_halt = 0;
    topup();
    step(); step();
    rst_n = 1;
    step();
    chk("restart_boot", 32'(id_valid), 0);
    step();
    chk("restart_instr", id_instr, WA);
    chk("restart_pc", id_pc, 0);
    mem[37] = HW; mem[200] = HW;
    for (int c = 0; c < 3000; c++) begin
      id_ready = ($urandom % 4) != 0;
      if ($urandom % 8 == 0)
        redirect(2'($urandom), $urandom, 16'($urandom), 26'($urandom), $urandom);
      else begin
        redir_valid = 0; exp_err = 0;
      end
      step();
      chk("rand_adr_err", 32'(adr_err), 32'(exp_err));
    end
    chk("rand_handshakes", 32'(hs > 200), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction-fetch stage placed directly upstream of the word-addressed instruction memory. Holds the PC, drives the memory address, captures the returned word into an IF/ID register with a valid/ready handshake toward decode, and computes redirect targets for branch, jump and register-jump requests coming back from decode/execute. Detects a halt word and parks the fetch stream.

## Interface
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `HALT_WORD`, 32'hFFFF_FFFF: fetched word that halts fetch.
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `imem_adr` out 32: byte address to instruction memory (= PC); memory indexes `adr[31:2]`.
- `imem_data` in 32: instruction word, combinational in `imem_adr`.
- `redir_valid` in 1: redirect request, single-cycle.
- `redir_kind` in 2: 0 = BEQ taken, 1 = J, 2 = JAL, 3 = JR.
- `redir_pc` in 32: PC of the redirecting instruction.
- `redir_imm` in 16: branch offset (words).
- `redir_jaddr` in 26: jump field.
- `redir_rs` in 32: register value for JR.
- `id_valid` out 1; `id_ready` in 1: IF/ID handshake.
- `id_instr` out 32; `id_pc` out 32; `id_pc_plus4` out 32: IF/ID payload.
- `halted` out 1: fetch parked on halt word.
- `adr_err` out 1: one-cycle pulse, JR target misaligned.
- `perf_fetched` out 32; `perf_stalls` out 32: counters (see Configuration).

## Operation
- FSM states BOOT, RUN, HALT. Reset → BOOT. BOOT → RUN unconditionally next cycle, no fetch in BOOT.
- RUN, "advance" = `!id_valid || id_ready`. On advance: if `imem_data == HALT_WORD` → HALT, `id_valid`<=0, PC held; else IF/ID <= {imem_data, PC, PC+4}, `id_valid`<=1, PC<=PC+4.
- RUN, no advance (stall): PC and IF/ID held, `id_valid` stays 1.
- HALT: PC, IF/ID frozen, `id_valid`=0 after the in-flight word is consumed (`id_valid` clears on `id_ready`), `halted`=1. Exit only by redirect or reset.
- Redirect (any state except BOOT; ignored in BOOT): PC<=target, `id_valid`<=0 (flush), state<=RUN. Redirect beats stall, halt detection and advance in the same cycle.
- Targets, all 32-bit, wrap mod 2^32: BEQ = redir_pc + 4 + (sign_extend(redir_imm) << 2); J/JAL = {(redir_pc+4)[31:28], redir_jaddr, 2'b00}; JR = {redir_rs[31:2], 2'b00}, `adr_err` pulses if `redir_rs[1:0] != 0`. JAL link write is decode's job, not this block.
- PC increment wraps 32'hFFFF_FFFC → 0.

## Timing
- Reset values: PC=`RESET_PC` (so `imem_adr`=`RESET_PC`), `id_valid`=0, `id_instr`/`id_pc`/`id_pc_plus4`=0, `halted`=0, `adr_err`=0, counters 0.
- First `id_valid` at second rising edge after reset release (BOOT + one fetch).
- Throughput one instruction/cycle with `id_ready` held high; fetch latency one cycle (PC → IF/ID).
- Redirect: target on `imem_adr` the cycle after `redir_valid`; target instruction valid at `id_*` one cycle later (1 bubble).
- Payload stable while `id_valid && !id_ready`.
- Reset asserted mid-operation: all state returns to reset values immediately, no partial flush.

## Configuration
- `FETCH_PERF_CNT_EN` defined: `perf_fetched` increments on each IF/ID load; `perf_stalls` increments each RUN cycle with `id_valid && !id_ready`; both wrap, both clear on reset.
- Undefined: counters not built, both ports tied to 0.

## Structure
- Package `fetch_pkg`: `fetch_state_e` (BOOT/RUN/HALT), `redir_kind_e`, default `HALT_WORD`, `PC_STEP` = 4.
- Sub-module `next_pc_calc`: purely combinational target computation and `adr_err`; FSM, PC and IF/ID register stay in `instr_fetch`.

## Test plan
- Reset, memory words 0..3 = A,B,C,D, `id_ready`=1 → `id_instr` A,B,C,D on cycles 2..5, `id_pc` 0,4,8,12.
- `id_ready`=0 for 3 cycles while `id_instr`=B → B held, PC held at 8, `perf_stalls`=3 (with macro), then C next.
- BEQ redirect, `redir_pc`=0x10, imm=16'hFFFE → next `imem_adr`=0x0C, one bubble, in-flight word flushed.
- J with `redir_pc`=0xF000_0000, jaddr=26'h000_0040 → target 0xF000_0100; JR `redir_rs`=0x0000_0203 → target 0x200, `adr_err` pulse.
- Word at 0x08 = 32'hFFFF_FFFF → `halted`=1, `id_valid` 0 after B consumed, PC stays 8; later JR to 0 → RUN, A refetched.
- Assert `rst_n` during stall with redirect pending → all outputs to reset values same cycle, restart at `RESET_PC`.
